// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer for the pipelined MIPS core.
// Owns the fetch PC, captures the instruction returned by a combinational
// instruction memory into a DEPTH-entry circular queue together with its
// PC+4, and presents the oldest entry to decode via a valid/ready handshake.
// An EX-stage redirect flushes the queue and restarts fetch at redirect_pc.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   imem_pc        fetch address to instruction memory (always = pc)
//   imem_instr     instruction at imem_pc, valid in the same cycle
//   redirect_valid EX-stage redirect request (highest priority)
//   redirect_pc    redirect target
//   out_valid      head entry present
//   out_instr      head instruction
//   out_pcplus4    PC+4 of the head instruction
//   out_ready      decode accepts the head this cycle
//   full           queue holds DEPTH entries
//   flush_cnt      (FETCH_QUEUE_PERF_EN only) saturating count of redirect cycles
//   stall_cnt      (FETCH_QUEUE_PERF_EN only) saturating count of full-and-no-dequeue cycles
//
// Optional feature macro: FETCH_QUEUE_PERF_EN.

module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned DW       = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   output logic [31:0]   imem_pc,
   input  logic [DW-1:0] imem_instr,
   input  logic          redirect_valid,
   input  logic [31:0]   redirect_pc,
   output logic          out_valid,
   output logic [DW-1:0] out_instr,
   output logic [31:0]   out_pcplus4,
   input  logic          out_ready,
`ifdef FETCH_QUEUE_PERF_EN
   output logic          full,
   output logic [31:0]   flush_cnt,
   output logic [31:0]   stall_cnt
`else
   output logic          full
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]   pc_q, pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [DW-1:0] instr_q  [DEPTH];
   logic [31:0]   pcplus4_q[DEPTH];

   logic deq_c;
   logic enq_c;

   // Handshake events; a redirect suppresses both enqueue and dequeue.
   assign deq_c = out_valid & out_ready & ~redirect_valid;
   assign enq_c = ~redirect_valid & ((count_q < CW'(DEPTH)) | deq_c);

   // Outputs derived purely from registered state.
   assign imem_pc     = pc_q;
   assign out_valid   = (count_q != '0);
   assign full        = (count_q == CW'(DEPTH));
   assign out_instr   = instr_q[rd_ptr_q];
   assign out_pcplus4 = pcplus4_q[rd_ptr_q];

   // Next-state for pc, pointers and occupancy.
   always_comb begin
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect_valid) begin
         pc_d     = redirect_pc;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq_c) begin
            pc_d     = pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (deq_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(enq_c) - CW'(deq_c);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care while unoccupied, so no reset.
   always_ff @(posedge clk) begin
      if (!reset && enq_c) begin
         instr_q[wr_ptr_q]   <= imem_instr;
         pcplus4_q[wr_ptr_q] <= pc_q + 32'd4;
      end
   end

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] flush_cnt_q, flush_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign flush_cnt = flush_cnt_q;
   assign stall_cnt = stall_cnt_q;

   // Saturating performance counters.
   always_comb begin
      flush_cnt_d = flush_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (redirect_valid && (flush_cnt_q != 32'hFFFF_FFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
      if (full && !deq_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flush_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random
// redirect/ready traffic, all compared against a queue-based reference model.

module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_ready;

   logic [31:0] imem_pc, imem_instr, out_instr, out_pcplus4;
   logic        out_valid, full;

   logic [31:0] imem_pc1, imem_instr1, out_instr1, out_pcplus41;
   logic        out_valid1, full1;

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] flush_cnt, stall_cnt, flush_cnt1, stall_cnt1;
   int unsigned m_flush, m_stall;
`endif

   int unsigned total  = 0;
   int unsigned passed = 0;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] p4;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mpc;

   always #5 clk = ~clk;

   function automatic logic [31:0] ifun(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign imem_instr  = ifun(imem_pc);
   assign imem_instr1 = ifun(imem_pc1);

   fetch_queue #(.DEPTH(DEPTH), .DW(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .imem_pc(imem_pc), .imem_instr(imem_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_instr(out_instr), .out_pcplus4(out_pcplus4),
      .out_ready(out_ready),
`ifdef FETCH_QUEUE_PERF_EN
      .full(full), .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
`else
      .full(full)
`endif
   );

   // Second instance exercises pc+4 wrap from the top of the address space.
   fetch_queue #(.DEPTH(DEPTH), .DW(32), .RESET_PC(32'hFFFF_FFF8)) dut1 (
      .clk(clk), .reset(reset), .imem_pc(imem_pc1), .imem_instr(imem_instr1),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .out_valid(out_valid1), .out_instr(out_instr1), .out_pcplus4(out_pcplus41),
      .out_ready(1'b1),
`ifdef FETCH_QUEUE_PERF_EN
      .full(full1), .flush_cnt(flush_cnt1), .stall_cnt(stall_cnt1)
`else
      .full(full1)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      mpc = 32'h0;
`ifdef FETCH_QUEUE_PERF_EN
      m_flush = 0;
      m_stall = 0;
`endif
   endtask

   task automatic check_outputs();
      check("imem_pc", imem_pc, mpc);
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      if (mq.size() != 0) begin
         check("out_instr", out_instr, mq[0].ins);
         check("out_pcplus4", out_pcplus4, mq[0].p4);
      end
`ifdef FETCH_QUEUE_PERF_EN
      check("flush_cnt", flush_cnt, m_flush);
      check("stall_cnt", stall_cnt, m_stall);
`endif
   endtask

   // Called at a negedge: check, drive one cycle of inputs, advance the model.
   task automatic step(input logic v, input logic [31:0] p, input logic r);
      bit d;
      check_outputs();
      redirect_valid = v;
      redirect_pc    = p;
      out_ready      = r;
      d = !v && r && (mq.size() != 0);
`ifdef FETCH_QUEUE_PERF_EN
      if (v) m_flush++;
      if (mq.size() == DEPTH && !d) m_stall++;
`endif
      if (v) begin
         mq.delete();
         mpc = p;
      end else begin
         if (d) void'(mq.pop_front());
         if (mq.size() < DEPTH) begin
            mq.push_back('{ins: ifun(mpc), p4: mpc + 32'd4});
            mpc = mpc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] base1;
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      out_ready = 1'b0;
      model_reset();
      #2;
      check_outputs();
      check("rst_imem_pc1", imem_pc1, 32'hFFFF_FFF8);
      @(negedge clk);
      reset = 1'b0;

      // Fill from reset with out_ready=0; wrap instance streams alongside.
      base1 = 32'hFFFF_FFF8;
      for (int k = 0; k < 6; k++) begin
         logic [31:0] e1;
         e1 = base1 + 32'(4 * k);
         check("imem_pc1", imem_pc1, e1);
         if (k > 0) begin
            check("out_valid1", 32'(out_valid1), 32'd1);
            check("out_pcplus4_1", out_pcplus41, e1);
            check("out_instr1", out_instr1, ifun(e1 - 32'd4));
         end
         step(1'b0, 32'h0, 1'b0);
      end
      check("fill_pc_hold", imem_pc, 32'd16);
      check("fill_head_p4", out_pcplus4, 32'd4);

      // Full queue streaming across pointer wrap.
      for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1);
      check("stream_head_p4", out_pcplus4, 32'd36);

      // Redirect while streaming, then follow the new target.
      step(1'b1, 32'h0000_0100, 1'b1);
      check("redir_valid", 32'(out_valid), 32'd0);
      check("redir_pc", imem_pc, 32'h0000_0100);
      step(1'b0, 32'h0, 1'b1);
      check("redir_head_p4", out_pcplus4, 32'h0000_0104);

      // Redirect near the top of memory, then two more redirects for the counters.
      step(1'b1, 32'hFFFF_FFF8, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1);
      step(1'b1, 32'h0000_0200, 1'b0);
      step(1'b1, 32'h0000_0300, 1'b0);

      // Build count=3, then assert reset between edges.
      for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0);
      check_outputs();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs();
      check("async_valid", 32'(out_valid), 32'd0);
      check("async_full", 32'(full), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
      reset = 1'b0;

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         logic        v;
         logic        r;
         logic [31:0] p;
         v = ($urandom_range(0, 9) == 0);
         r = ($urandom_range(0, 3) != 0);
         p = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
         step(v, p, r);
      end
      check_outputs();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
